// File: rtl/usb_rx_sequencer.sv
// Receive-side sequencer for the USB full-speed receiver.
// Walks one packet through SYNC check, byte hand-off to the RX FIFO, EOP qualification and error recovery.
module usb_rx_sequencer #(
   parameter int          MAX_BYTES = 64,
   parameter logic [7:0]  SYNC_BYTE = 8'h80
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       d_edge,
   input  logic       shift_enable,
   input  logic       eop,
   input  logic       byte_received,
   input  logic [7:0] rcv_data,
   output logic       rcving,
   output logic       timer_enable,
   output logic       w_enable,
   output logic [7:0] rx_data,
   output logic [7:0] byte_count,
   output logic       r_error,
   output logic       packet_done
);

   localparam logic [7:0] MAX_COUNT = 8'(MAX_BYTES);

   typedef enum logic [3:0] {
      IDLE,
      SYNC_WAIT,
      SYNC_CHECK,
      RECEIVE,
      WRITE,
      BYTE_GAP,
      EOP_HOLD,
      EOP_END,
      DONE,
      ERR_WAIT,
      ERR_END
   } state_t;

   state_t state;
   state_t next_state;

   logic se;
   logic at_max;
   logic set_error;
   logic clear_packet;

   assign se     = shift_enable & eop;
   assign at_max = (byte_count == MAX_COUNT);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A qualified EOP always wins over a byte arriving in the same cycle.
   always_comb begin
      next_state   = state;
      set_error    = 1'b0;
      clear_packet = 1'b0;
      case (state)
         IDLE: begin
            if (d_edge) begin
               next_state   = SYNC_WAIT;
               clear_packet = 1'b1;
            end
         end
         SYNC_WAIT: begin
            if (se) begin
               next_state = ERR_END;
               set_error  = 1'b1;
            end else if (byte_received) begin
               next_state = SYNC_CHECK;
            end
         end
         SYNC_CHECK: begin
            if (rx_data == SYNC_BYTE) begin
               next_state = RECEIVE;
            end else begin
               next_state = ERR_WAIT;
               set_error  = 1'b1;
            end
         end
         RECEIVE: begin
            if (se) begin
               next_state = ERR_END;
               set_error  = 1'b1;
            end else if (byte_received) begin
               if (at_max) begin
                  next_state = ERR_WAIT;
                  set_error  = 1'b1;
               end else begin
                  next_state = WRITE;
               end
            end
         end
         WRITE: begin
            next_state = BYTE_GAP;
         end
         BYTE_GAP: begin
            if (se) begin
               next_state = EOP_HOLD;
            end else if (shift_enable) begin
               next_state = RECEIVE;
            end
         end
         // A lone SE0 bit is not a valid EOP.
         EOP_HOLD: begin
            if (se) begin
               next_state = EOP_END;
            end else if (shift_enable) begin
               next_state = ERR_WAIT;
               set_error  = 1'b1;
            end
         end
         EOP_END: begin
            if (d_edge) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         ERR_WAIT: begin
            if (se) begin
               next_state = ERR_END;
            end
         end
         ERR_END: begin
            if (d_edge) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rx_data <= 8'h00;
      end else if (byte_received) begin
         rx_data <= rcv_data;
      end
   end

   // The count saturates at MAX_BYTES and holds through IDLE until the next packet.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         byte_count <= 8'h00;
      end else if (clear_packet) begin
         byte_count <= 8'h00;
      end else if ((state == WRITE) && !at_max) begin
         byte_count <= byte_count + 8'h01;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_error <= 1'b0;
      end else if (clear_packet) begin
         r_error <= 1'b0;
      end else if (set_error) begin
         r_error <= 1'b1;
      end
   end

   always_comb begin
      rcving       = (state != IDLE);
      w_enable     = (state == WRITE);
      packet_done  = (state == DONE);
      timer_enable = 1'b0;
      case (state)
         SYNC_WAIT, SYNC_CHECK, RECEIVE, WRITE,
         BYTE_GAP, EOP_HOLD, ERR_WAIT: timer_enable = 1'b1;
         default:                      timer_enable = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Randomized bench for usb_rx_sequencer: packets of assorted shapes are driven and
// outcomes compared against a packet-level model of the receive rules.
module tb_usb_rx_sequencer;

   localparam int MAX_BYTES = 4;

   localparam int K_CLEAN    = 0;
   localparam int K_BADSYNC  = 1;
   localparam int K_MIDEOP   = 2;
   localparam int K_OVERFLOW = 3;
   localparam int K_SINGLE   = 4;
   localparam int K_PRIORITY = 5;
   localparam int K_SYNCEOP  = 6;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       d_edge;
   logic       shift_enable;
   logic       eop;
   logic       byte_received;
   logic [7:0] rcv_data;
   logic       rcving;
   logic       timer_enable;
   logic       w_enable;
   logic [7:0] rx_data;
   logic [7:0] byte_count;
   logic       r_error;
   logic       packet_done;

   int         tests_run    = 0;
   int         tests_failed = 0;
   logic [7:0] exp_q[$];
   logic [7:0] pkt_data[0:7];
   int         wr_count;
   int         done_seen;

   usb_rx_sequencer #(.MAX_BYTES(MAX_BYTES), .SYNC_BYTE(8'h80)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .d_edge        (d_edge),
      .shift_enable  (shift_enable),
      .eop           (eop),
      .byte_received (byte_received),
      .rcv_data      (rcv_data),
      .rcving        (rcving),
      .timer_enable  (timer_enable),
      .w_enable      (w_enable),
      .rx_data       (rx_data),
      .byte_count    (byte_count),
      .r_error       (r_error),
      .packet_done   (packet_done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs from a negedge, then inspects the response at the next negedge.
   task automatic stepCycle(input logic de, input logic sen, input logic eo, input logic br, input logic [7:0] data);
      d_edge        = de;
      shift_enable  = sen;
      eop           = eo;
      byte_received = br;
      rcv_data      = data;
      @(posedge clk);
      @(negedge clk);
      d_edge        = 1'b0;
      shift_enable  = 1'b0;
      eop           = 1'b0;
      byte_received = 1'b0;
      if (w_enable) begin
         checkOutput("write_follows_byte", 32'(br), 1);
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_write", 32'(w_enable), 0);
         end else begin
            checkOutput("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            checkOutput("count_at_write", 32'(byte_count), 32'(wr_count));
            wr_count++;
         end
      end
      if (packet_done) done_seen++;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // Bit strobes with stray line edges; harmless in SYNC_WAIT, RECEIVE and ERR_WAIT.
   task automatic fillerBits();
      int k;
      k = int'($urandom_range(0, 3));
      for (int i = 0; i < k; i++)
         stepCycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'($urandom_range(0, 255)));
   endtask

   task automatic sendByte(input logic [7:0] v);
      stepCycle(1'b0, 1'b0, 1'b0, 1'b1, v);
      idleCycles(2);
   endtask

   task automatic applyStimulus(input int kind, input int n, input logic [7:0] bad_sync);
      int         accepted;
      logic       exp_err;
      int         exp_done;
      logic [7:0] sync_val;

      accepted = (kind == K_BADSYNC || kind == K_SYNCEOP) ? 0 : ((n > MAX_BYTES) ? MAX_BYTES : n);
      exp_err  = (kind != K_CLEAN);
      exp_done = (kind == K_CLEAN) ? 1 : 0;
      exp_q.delete();
      for (int i = 0; i < accepted; i++) exp_q.push_back(pkt_data[i]);
      wr_count  = 0;
      done_seen = 0;

      stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("start_rcving", 32'(rcving), 1);
      checkOutput("start_timer", 32'(timer_enable), 1);
      checkOutput("start_count", 32'(byte_count), 0);
      checkOutput("start_clears_err", 32'(r_error), 0);
      fillerBits();

      if (kind == K_SYNCEOP) begin
         stepCycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
         checkOutput("sync_eop_err", 32'(r_error), 1);
         checkOutput("err_end_timer", 32'(timer_enable), 0);
         stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      end else begin
         sync_val = (kind == K_BADSYNC) ? bad_sync : 8'h80;
         stepCycle(1'b0, 1'b0, 1'b0, 1'b1, sync_val);
         checkOutput("sync_check_err", 32'(r_error), 0);
         stepCycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         checkOutput("sync_result_err", 32'(r_error), (kind == K_BADSYNC) ? 1 : 0);

         if (kind == K_BADSYNC) begin
            for (int i = 0; i < n; i++) begin
               fillerBits();
               sendByte(pkt_data[i]);
            end
         end else begin
            for (int i = 0; i < n; i++) begin
               if (i > 0) stepCycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
               fillerBits();
               sendByte(pkt_data[i]);
            end
         end

         case (kind)
            K_CLEAN: begin
               stepCycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
               checkOutput("eop_hold_timer", 32'(timer_enable), 1);
               stepCycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
               checkOutput("eop_end_timer", 32'(timer_enable), 0);
               checkOutput("eop_end_rcving", 32'(rcving), 1);
               idleCycles(int'($urandom_range(0, 2)));
               stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
               checkOutput("done_pulse", 32'(packet_done), 1);
               stepCycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
               checkOutput("rcving_after_done", 32'(rcving), 0);
            end
            K_MIDEOP, K_PRIORITY: begin
               if (n > 0) stepCycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
               fillerBits();
               if (kind == K_PRIORITY)
                  stepCycle(1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
               else
                  stepCycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
               checkOutput("early_eop_err", 32'(r_error), 1);
               checkOutput("err_end_timer", 32'(timer_enable), 0);
               stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            end
            K_SINGLE: begin
               stepCycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
               checkOutput("single_hold_err", 32'(r_error), 0);
               stepCycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
               checkOutput("single_se0_err", 32'(r_error), 1);
               stepCycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
               stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            end
            default: begin
               stepCycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
               checkOutput("err_wait_exit_err", 32'(r_error), 1);
               stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            end
         endcase
      end

      idleCycles(2 + int'($urandom_range(0, 2)));
      checkOutput("end_rcving", 32'(rcving), 0);
      checkOutput("end_timer", 32'(timer_enable), 0);
      checkOutput("end_count", 32'(byte_count), 32'(accepted));
      checkOutput("end_err", 32'(r_error), 32'(exp_err));
      checkOutput("done_count", 32'(done_seen), 32'(exp_done));
      checkOutput("missing_writes", 32'(exp_q.size()), 0);
   endtask

   task automatic resetDuringWrite();
      exp_q.delete();
      pkt_data[0] = 8'h11;
      exp_q.push_back(pkt_data[0]);
      wr_count  = 0;
      done_seen = 0;
      stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      sendByte(8'h80);
      sendByte(pkt_data[0]);
      stepCycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      byte_received = 1'b1;
      rcv_data      = 8'h5A;
      @(posedge clk);
      #2;
      byte_received = 1'b0;
      checkOutput("pre_reset_write", 32'(w_enable), 1);
      checkOutput("pre_reset_count", 32'(byte_count), 1);
      n_rst = 1'b0;
      #1;
      checkOutput("rst_rcving", 32'(rcving), 0);
      checkOutput("rst_timer", 32'(timer_enable), 0);
      checkOutput("rst_w_enable", 32'(w_enable), 0);
      checkOutput("rst_rx_data", 32'(rx_data), 0);
      checkOutput("rst_count", 32'(byte_count), 0);
      checkOutput("rst_err", 32'(r_error), 0);
      checkOutput("rst_done", 32'(packet_done), 0);
      @(negedge clk);
      n_rst = 1'b1;
      idleCycles(3);
      checkOutput("post_rst_rcving", 32'(rcving), 0);
      checkOutput("post_rst_done", 32'(done_seen), 0);
   endtask

   initial begin
      int         kind;
      int         n;
      logic [7:0] bad;
      n_rst         = 1'b1;
      d_edge        = 1'b0;
      shift_enable  = 1'b0;
      eop           = 1'b0;
      byte_received = 1'b0;
      rcv_data      = 8'h00;
      wr_count      = 0;
      done_seen     = 0;
      #2 n_rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_rcving", 32'(rcving), 0);
      checkOutput("reset_timer", 32'(timer_enable), 0);
      checkOutput("reset_count", 32'(byte_count), 0);
      checkOutput("reset_err", 32'(r_error), 0);
      checkOutput("reset_rx_data", 32'(rx_data), 0);
      n_rst = 1'b1;
      idleCycles(2);

      pkt_data[0] = 8'hA5;
      pkt_data[1] = 8'h3C;
      applyStimulus(K_CLEAN, 2, 8'h00);
      applyStimulus(K_BADSYNC, 1, 8'h81);
      applyStimulus(K_CLEAN, 1, 8'h00);
      applyStimulus(K_MIDEOP, 1, 8'h00);
      for (int i = 0; i < 8; i++) pkt_data[i] = 8'(8'h20 + i);
      applyStimulus(K_OVERFLOW, MAX_BYTES + 1, 8'h00);
      applyStimulus(K_SINGLE, 2, 8'h00);
      resetDuringWrite();
      applyStimulus(K_PRIORITY, 1, 8'h00);
      applyStimulus(K_SYNCEOP, 0, 8'h00);

      for (int p = 0; p < 60; p++) begin
         kind = int'($urandom_range(0, 6));
         for (int i = 0; i < 8; i++) pkt_data[i] = 8'($urandom_range(0, 255));
         do bad = 8'($urandom_range(0, 255)); while (bad == 8'h80);
         case (kind)
            K_CLEAN, K_SINGLE:   n = int'($urandom_range(1, MAX_BYTES));
            K_MIDEOP, K_PRIORITY: n = int'($urandom_range(0, MAX_BYTES));
            K_OVERFLOW:          n = int'($urandom_range(MAX_BYTES + 1, MAX_BYTES + 2));
            K_BADSYNC:           n = int'($urandom_range(0, 2));
            default:             n = 0;
         endcase
         applyStimulus(kind, n, bad);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/usb_rx_sequencer.md
# usb_rx_sequencer

Receive-side control unit for the USB full-speed receiver. It sequences the NRZI decoder, bit timer and 8-bit shift register datapath through one packet: SYNC validation, data-byte hand-off to the RX FIFO, EOP qualification and error recovery. It sits between the line-level datapath (decoder, edge detector, timer, shift register) and the RX FIFO / protocol layer.

## Interface
- MAX_BYTES, 64: maximum data bytes accepted per packet after SYNC (1..255).
- SYNC_BYTE, 8'h80: expected value of the first assembled byte (LSB-first SYNC).
- clk  in  1  system clock.
- n_rst  in  1  reset, asynchronous, active-low.
- d_edge  in  1  one-cycle pulse on any detected line transition.
- shift_enable  in  1  one-cycle bit-period strobe from the bit timer.
- eop  in  1  SE0 detected on the line; qualified only when shift_enable=1.
- byte_received  in  1  one-cycle pulse: shift register holds 8 new bits.
- rcv_data  in  8  assembled byte; valid in the byte_received cycle.
- rcving  out  1  packet in progress.
- timer_enable  out  1  enables the bit timer.
- w_enable  out  1  one-cycle FIFO write strobe.
- rx_data  out  8  captured byte; valid while w_enable=1.
- byte_count  out  8  data bytes written in the current packet.
- r_error  out  1  sticky packet error flag.
- packet_done  out  1  one-cycle pulse on clean packet completion.

## Operation
- Notation: SE = shift_enable & eop. SE has priority over byte_received in the same cycle.
- rx_data is loaded from rcv_data on every byte_received cycle.
- States:
  - IDLE: d_edge leads to SYNC_WAIT; on that edge r_error is cleared and byte_count is reset to 0.
  - SYNC_WAIT: SE leads to ERR_END and sets r_error. Otherwise byte_received leads to SYNC_CHECK.
  - SYNC_CHECK (1 cycle): if rx_data==SYNC_BYTE, go to RECEIVE; otherwise go to ERR_WAIT and set r_error.
  - RECEIVE:
    - SE (EOP mid-byte) leads to ERR_END and sets r_error.
    - byte_received with byte_count==MAX_BYTES leads to ERR_WAIT, sets r_error, and performs no write.
    - Any other byte_received leads to WRITE.
  - WRITE (1 cycle): w_enable=1; byte_count increments; go to BYTE_GAP.
  - BYTE_GAP: SE leads to EOP_HOLD; shift_enable&!eop leads to RECEIVE.
  - EOP_HOLD: SE leads to EOP_END; shift_enable&!eop (single-bit SE0) leads to ERR_WAIT and sets r_error.
  - EOP_END: d_edge (return to J) leads to DONE.
  - DONE (1 cycle): packet_done=1; go to IDLE.
  - ERR_WAIT: SE leads to ERR_END; byte_received is ignored and nothing is written.
  - ERR_END: d_edge leads to IDLE. r_error stays 1 until the next packet's first d_edge in IDLE.
- Moore outputs:
  - rcving=1 in every state except IDLE.
  - timer_enable=1 in SYNC_WAIT, SYNC_CHECK, RECEIVE, WRITE, BYTE_GAP, EOP_HOLD and ERR_WAIT.
- byte_count never exceeds MAX_BYTES and never wraps. It holds its final value through IDLE until the next packet starts.
- A d_edge arriving in any state other than IDLE, EOP_END or ERR_END is ignored.

## Timing
- Reset (asynchronous, immediate): state=IDLE; all outputs 0, including rx_data=0, byte_count=0 and r_error=0. A reset mid-packet aborts it; no w_enable or packet_done is issued.
- Clock edge numbering: byte_received is high in cycle t.
  - w_enable=1 and rx_data valid in cycle t+1.
  - byte_count shows the incremented value from cycle t+2.
- Start of packet: d_edge in cycle t gives rcving=1 and timer_enable=1 in cycle t+1.
- SYNC result: byte_received in cycle t puts the FSM in SYNC_CHECK in cycle t+1 and in RECEIVE or ERR_WAIT in cycle t+2. r_error becomes visible in cycle t+2.
- Completion: d_edge in EOP_END during cycle t gives packet_done=1 in cycle t+1, and rcving=0 from cycle t+2.
- Errors: r_error rises the cycle after the error condition is sampled. It never pulses; it holds until cleared.
- No output depends combinationally on any input.

## Test plan
- Clean packet:
  - Stimulus: d_edge, SYNC 8'h80, data bytes 8'hA5 and 8'h3C, then SE, SE, d_edge.
  - Response: two w_enable pulses with rx_data A5 then 3C; byte_count=2; one packet_done; r_error=0; rcving returns to 0.
- Bad SYNC:
  - Stimulus: first byte 8'h81.
  - Response: r_error=1 two cycles after byte_received; zero w_enable; after SE, d_edge the FSM is in IDLE with r_error still 1; the next packet's d_edge clears it.
- Mid-byte EOP:
  - Stimulus: SYNC, one data byte, a BYTE_GAP bit, then SE while in RECEIVE.
  - Response: r_error=1; byte_count=1; no packet_done.
- Overflow:
  - Stimulus: MAX_BYTES=4; SYNC plus 5 data bytes.
  - Response: exactly 4 w_enable pulses; byte_count=4; the 5th byte sets r_error and is not written.
- Single-bit SE0:
  - Stimulus: SE in BYTE_GAP, then shift_enable&!eop.
  - Response: r_error=1; no packet_done.
- Reset and priority:
  - Stimulus: assert n_rst low during WRITE.
  - Response: all outputs 0 immediately.
  - Stimulus: SE and byte_received in the same RECEIVE cycle.
  - Response: error path taken; no w_enable.
